// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, WIDTH steps per
// signed product, with a registered product and a one-cycle done pulse.
module booth_seq_mult #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t               state_q;
  logic [WIDTH:0]       a_q;
  logic [WIDTH:0]       m_q;
  logic [WIDTH-1:0]     q_q;
  logic                 q1_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_q;
  logic                 done_q;

  logic [WIDTH:0]       sum_d;
  logic [WIDTH:0]       a_d;
  logic [WIDTH-1:0]     q_d;
  logic                 q1_d;

  // A is one bit wider than the operands so subtracting the most negative M cannot overflow
  always_comb begin
    sum_d = a_q;
    unique case ({q_q[0], q1_q})
      2'b01:   sum_d = a_q + m_q;
      2'b10:   sum_d = a_q - m_q;
      default: sum_d = a_q;
    endcase
    a_d  = {sum_d[WIDTH], sum_d[WIDTH:1]};
    q_d  = {sum_d[0], q_q[WIDTH-1:1]};
    q1_d = q_q[0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            state_q <= CALC;
            m_q     <= {i_multiplicand[WIDTH-1], i_multiplicand};
            q_q     <= i_multiplier;
            a_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_WIDTH'(WIDTH - 1)) begin
            state_q   <= DONE;
            product_q <= {a_d[WIDTH-1:0], q_d};
            done_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH=4): hand-computed vector table,
// multi-cycle corner sequences, and an exhaustive back-to-back sweep.
module tb_booth_seq_mult;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic [3:0] i_multiplicand;
  logic [3:0] i_multiplier;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_product;

  booth_seq_mult #(.WIDTH(4), .CNT_WIDTH(3)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_product      (o_product)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] p;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         last_done_cyc = -1;
  bit         sweep = 1'b0;
  logic [7:0] last_prod = 8'h00;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge i_clk) begin
    if (!i_rst && o_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=%h required=none", o_product);
      end else begin
        chk("product", o_product, exp_q.pop_front());
      end
      if (sweep) begin
        if (last_done_cyc >= 0) chk("done_period", 8'(cyc - last_done_cyc), 8'd6);
        last_done_cyc = cyc;
      end
    end
  end

  // Issues one multiply from IDLE and checks timing around it
  task automatic run_vec(input logic [3:0] m, input logic [3:0] q, input logic [7:0] p);
    int n;
    bit seen;
    @(negedge i_clk);
    i_start = 1'b1;
    i_multiplicand = m;
    i_multiplier = q;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    exp_q.push_back(p);
    chk("busy_after_accept", 8'(o_busy), 8'd1);
    chk("product_held_calc", o_product, last_prod);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge i_clk); #1;
      n++;
      seen = o_done;
    end
    // done is seen after the WIDTH-th edge following accept (WIDTH+1 edges counting accept)
    chk("latency", 8'(n), 8'd4);
    last_prod = p;
    @(posedge i_clk); #1;
    chk("done_pulse_width", 8'(o_done), 8'd0);
    chk("busy_after_done", 8'(o_busy), 8'd0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("product_held_idle", o_product, p);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int prod;
    vecs[0]  = '{4'h3, 4'hE, 8'hFA};
    vecs[1]  = '{4'h8, 4'h8, 8'h40};
    vecs[2]  = '{4'h8, 4'h7, 8'hC8};
    vecs[3]  = '{4'h7, 4'h7, 8'h31};
    vecs[4]  = '{4'h0, 4'hB, 8'h00};
    vecs[5]  = '{4'hF, 4'hF, 8'h01};
    vecs[6]  = '{4'h1, 4'h8, 8'hF8};
    vecs[7]  = '{4'h8, 4'h1, 8'hF8};
    vecs[8]  = '{4'h5, 4'hD, 8'hF1};
    vecs[9]  = '{4'h7, 4'h8, 8'hC8};
    vecs[10] = '{4'hF, 4'h7, 8'hF9};
    vecs[11] = '{4'h2, 4'h3, 8'h06};

    // start asserted during reset must be ignored
    i_rst = 1'b1;
    i_start = 1'b1;
    i_multiplicand = 4'h3;
    i_multiplier = 4'h3;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_busy", 8'(o_busy), 8'd0);
    chk("reset_done", 8'(o_done), 8'd0);
    chk("reset_product", o_product, 8'h00);
    @(negedge i_clk);
    i_start = 1'b0;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("idle_after_reset", 8'(o_busy), 8'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i].m, vecs[i].q, vecs[i].p);

    // start pulses during CALC are ignored; exactly one result for 3*3
    d0 = done_cnt;
    @(negedge i_clk);
    i_start = 1'b1;
    i_multiplicand = 4'h3;
    i_multiplier = 4'h3;
    @(posedge i_clk); #1;
    exp_q.push_back(8'h09);
    i_start = 1'b0;
    @(posedge i_clk); #1;
    i_start = 1'b1;
    i_multiplicand = 4'h7;
    i_multiplier = 4'h7;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(posedge i_clk); #1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    chk("ignored_start_done_count", 8'(done_cnt - d0), 8'd1);
    chk("ignored_start_product", o_product, 8'h09);
    last_prod = 8'h09;

    // reset at step 2 of 5*-3 discards the partial result
    @(negedge i_clk);
    i_start = 1'b1;
    i_multiplicand = 4'h5;
    i_multiplier = 4'hD;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    chk("midrun_reset_busy", 8'(o_busy), 8'd0);
    chk("midrun_reset_done", 8'(o_done), 8'd0);
    chk("midrun_reset_product", o_product, 8'h00);
    @(negedge i_clk);
    i_rst = 1'b0;
    last_prod = 8'h00;
    run_vec(4'h5, 4'hD, 8'hF1);

    // exhaustive sweep with start held high back-to-back
    sweep = 1'b1;
    @(negedge i_clk);
    i_start = 1'b1;
    i_multiplicand = 4'h0;
    i_multiplier = 4'h0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      logic [3:0] mv;
      logic [3:0] qv;
      iv = 8'(i);
      mv = iv[7:4];
      qv = iv[3:0];
      @(posedge i_clk); #1;
      prod = int'($signed(mv)) * int'($signed(qv));
      exp_q.push_back(8'(prod));
      if (i == 255) begin
        i_start = 1'b0;
      end else begin
        iv = 8'(i + 1);
        i_multiplicand = iv[7:4];
        i_multiplier = iv[3:0];
      end
      repeat (5) @(posedge i_clk);
      #1;
    end
    repeat (4) @(posedge i_clk);
    #1;
    sweep = 1'b0;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    chk("sweep_idle", 8'(o_busy), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
